port_ctrl: RTL and testbench
============================

// Module: port_ctrl
// PURPOSE
//  Access controller for the GPIO port block (DDRx/PORTx/PINx register file).
//  Shares the port's single write/read interface between two requesters: req0 = CPU core, req1 = debug/loader.
//  Arbitrates between them round-robin and keeps shadow copies of DDR/PORT.
//  Executes byte writes, bit set/clear/toggle as read-modify-write on the shadows, and PIN reads.
// PARAMETERS
//  DATA_W      8                  port data width
//  PORT_NUM    3                  number of ports (0=A,1=B,2=C)
//  PIDX_W      $clog2(PORT_NUM)   port index width (derived, localparam)
// PORTS
//  clk           in   1        clock
//  rst           in   1        reset, synchronous, active-high
//  reqN_valid    in   1        N=0,1; command valid, held stable until reqN_ack
//  reqN_op       in   3        op_e: WR_BYTE, SET_BIT, CLR_BIT, TGL_BIT, RD_PIN
//  reqN_reg      in   1        0=DDR, 1=PORT (ignored for RD_PIN)
//  reqN_port     in   PIDX_W   target port index
//  reqN_bit      in   3        bit index for SET/CLR/TGL
//  reqN_wdata    in   DATA_W   byte for WR_BYTE
//  reqN_ack      out  1        one-cycle completion pulse
//  reqN_err      out  1        valid with ack; port index >= PORT_NUM or illegal op
//  reqN_rdata    out  DATA_W   valid with ack; PIN value (RD_PIN) else new shadow byte
//  p_dane        out  DATA_W   to port: write data
//  p_nr_ddr      out  PIDX_W   to port: DDR index
//  p_nr_port     out  PIDX_W   to port: PORT index
//  p_nr_pin      out  PIDX_W   to port: PIN read index
//  p_wr_ddr      out  1        to port: DDR write strobe
//  p_wr_port     out  1        to port: PORT write strobe
//  p_pin_in      in   DATA_W   from port: PIN mux output
//  busy          out  1        state != IDLE
// BEHAVIOUR
//  - Reset:
//    - all outputs 0; state IDLE; rr pointer = 1, so req0 wins the first tie.
//    - Shadows: DDR[A]=DDR[B]=00, DDR[C]=FF, PORT[*]=00 (identical to port reset).
//    - Reset mid-operation aborts the op: no ack, no strobe.
//  - FSM IDLE -> EXEC -> DONE -> IDLE; 3 cycles per command; next grant possible in the cycle after DONE.
//  - IDLE: if any valid, rr arbiter grants one requester; its command is latched into cmd regs; go EXEC.
//    - Both valid: grant the requester != rr pointer; pointer <= granted.
//  - EXEC (registered outputs, exactly one cycle):
//    - new = WR_BYTE ? wdata : SET ? sh|(1<<bit) : CLR ? sh&~(1<<bit) : TGL ? sh^(1<<bit).
//    - Writes: p_dane=new, p_nr_ddr/p_nr_port=port, selected p_wr_* =1 for this cycle only.
//      The shadow is updated on the same edge.
//    - RD_PIN: p_nr_pin=port, no strobes; p_pin_in captured at end of EXEC.
//    - err (bad index/op): no strobe, no shadow change.
//  - DONE: granted reqN_ack=1 with rdata/err for one cycle; the other requester's ack stays 0.
//    - Requester drops valid or presents the next command the cycle after ack.
//  - p_nr_pin holds its last value outside EXEC; strobes are 0 outside EXEC.
//  - Requests arriving while busy wait; an ungranted valid is never dropped.
//  - Bit ops never read PIN, so input-bit values cannot corrupt PORT.
// STRUCTURE
//  - port_ctrl_pkg:
//    - op_e: WR_BYTE=0, SET_BIT=1, CLR_BIT=2, TGL_BIT=3, RD_PIN=4.
//    - state_e: IDLE, EXEC, DONE.
//    - reset constants: DDR_RST array (00,00,FF), PORT_RST=00.
//  - Sub-module rr_arbiter2: 2-way round-robin.
//    - Inputs: req[1:0], advance. Outputs: gnt one-hot, ptr.
//    - ptr updated only on advance (IDLE grant).
//  - Top holds FSM, cmd regs, shadow arrays, output regs.
// TESTING
//  - After rst: req0 SET_BIT port=2(C) reg=PORT bit=3 -> p_wr_port=1 for 1 cycle, p_dane=08.
//    ack exactly 2 cycles after grant cycle, rdata=08.
//  - req0 and req1 valid together, both WR_BYTE -> req0 served first.
//    Repeated contention alternates 1,0,1...; no ack overlap.
//  - DDR[A]=0F, PORT[A] WR_BYTE A5, then TGL bit 0 -> p_dane=A4.
//    Pins A[7:4] driven to 1 by the bench do not alter the result.
//  - RD_PIN port=1 with bench driving in_out_B=3C -> p_nr_pin=1 in EXEC, rdata=3C, no strobes.
//  - port=3 WR_BYTE -> ack with err=1, no p_wr_* pulse, shadows unchanged.
//  - rst asserted during EXEC -> no ack; outputs and shadows return to reset values next cycle.

Source files
------------

// File: rtl/port_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : port_ctrl_pkg
// Description : Shared types and constants for the GPIO port access
//               controller: command opcodes, FSM states, register-file
//               reset values and the latched command record.
// Revision    : 1.0 - initial release
// ============================================================================
package port_ctrl_pkg;

  localparam int DATA_W   = 8;
  localparam int PORT_NUM = 3;
  localparam int PIDX_W   = $clog2(PORT_NUM);

  typedef enum logic [2:0] {
    WR_BYTE = 3'd0,
    SET_BIT = 3'd1,
    CLR_BIT = 3'd2,
    TGL_BIT = 3'd3,
    RD_PIN  = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Port C powers up as output (DDR=FF); A and B as inputs.
  localparam logic [PORT_NUM-1:0][DATA_W-1:0] DDR_RST  = {8'hFF, 8'h00, 8'h00};
  localparam logic [DATA_W-1:0]               PORT_RST = 8'h00;

  // One requester's command as seen by the arbiter mux.
  typedef struct packed {
    logic [2:0]        op;
    logic              sel_port;   // 0 = DDR, 1 = PORT
    logic [PIDX_W-1:0] port;
    logic [2:0]        bit_idx;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  // Single-bit mask for the bit-manipulation ops.
  function automatic logic [DATA_W-1:0] bit_mask(input logic [2:0] b);
    return DATA_W'(1) << b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/port_ctrl_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin arbiter. On a tie the requester that is
//               not the pointer wins; the pointer then follows the grant, so
//               after an advance it names the requester currently served.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o,
  output logic       ptr_o
);

  logic ptr_q;

  // One-hot grant; a tie goes to the requester other than the pointer.
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = ptr_q ? 2'b01 : 2'b10;
    end
  end

  // Pointer tracks the most recent grant; reset to 1 so req0 wins first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b1;
    end else if (advance_i && (req_i != 2'b00)) begin
      ptr_q <= gnt_o[1];
    end
  end

  assign ptr_o = ptr_q;

endmodule
`default_nettype wire

// File: rtl/port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : port_ctrl
// Description : Access controller for the GPIO DDR/PORT/PIN register file.
//               Arbitrates CPU (req0) and debug/loader (req1) round-robin,
//               keeps DDR/PORT shadows and performs byte writes, bit
//               set/clear/toggle (read-modify-write on the shadows, never on
//               PIN) and PIN reads. Each command takes IDLE->EXEC->DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module port_ctrl
  import port_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid_i,
  input  logic [2:0]        req0_op_i,
  input  logic              req0_reg_i,
  input  logic [PIDX_W-1:0] req0_port_i,
  input  logic [2:0]        req0_bit_i,
  input  logic [DATA_W-1:0] req0_wdata_i,
  output logic              req0_ack_o,
  output logic              req0_err_o,
  output logic [DATA_W-1:0] req0_rdata_o,
  input  logic              req1_valid_i,
  input  logic [2:0]        req1_op_i,
  input  logic              req1_reg_i,
  input  logic [PIDX_W-1:0] req1_port_i,
  input  logic [2:0]        req1_bit_i,
  input  logic [DATA_W-1:0] req1_wdata_i,
  output logic              req1_ack_o,
  output logic              req1_err_o,
  output logic [DATA_W-1:0] req1_rdata_o,
  output logic [DATA_W-1:0] p_dane_o,
  output logic [PIDX_W-1:0] p_nr_ddr_o,
  output logic [PIDX_W-1:0] p_nr_port_o,
  output logic [PIDX_W-1:0] p_nr_pin_o,
  output logic              p_wr_ddr_o,
  output logic              p_wr_port_o,
  input  logic [DATA_W-1:0] p_pin_in_i,
  output logic              busy_o
);

  state_e                            state_q;
  logic [PORT_NUM-1:0][DATA_W-1:0]   ddr_q;
  logic [PORT_NUM-1:0][DATA_W-1:0]   prt_q;

  // Latched command (only what EXEC still needs)
  logic                              rd_q;
  logic                              sel_q;
  logic [PIDX_W-1:0]                 port_q;
  logic                              cerr_q;
  logic [DATA_W-1:0]                 new_q;

  // Registered outputs
  logic [DATA_W-1:0]                 dane_q;
  logic [PIDX_W-1:0]                 nr_ddr_q;
  logic [PIDX_W-1:0]                 nr_port_q;
  logic [PIDX_W-1:0]                 nr_pin_q;
  logic                              wr_ddr_q;
  logic                              wr_port_q;
  logic [1:0]                        ack_q;
  logic                              rerr_q;
  logic [DATA_W-1:0]                 rdata_q;

  logic [1:0]                        req;
  logic [1:0]                        gnt;
  logic                              owner;
  cmd_t                              cmd0;
  cmd_t                              cmd1;
  cmd_t                              cmd_sel;
  logic                              port_ok;
  logic                              op_ok;
  logic [DATA_W-1:0]                 cur;
  logic [DATA_W-1:0]                 new_d;

  assign req  = {req1_valid_i, req0_valid_i};
  assign cmd0 = '{op: req0_op_i, sel_port: req0_reg_i, port: req0_port_i,
                  bit_idx: req0_bit_i, wdata: req0_wdata_i};
  assign cmd1 = '{op: req1_op_i, sel_port: req1_reg_i, port: req1_port_i,
                  bit_idx: req1_bit_i, wdata: req1_wdata_i};

  // The arbiter only advances in IDLE, so from EXEC onward its pointer
  // names the requester being served and routes the ack.
  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req),
    .advance_i (state_q == IDLE),
    .gnt_o     (gnt),
    .ptr_o     (owner)
  );

  // Granted command mux and the resulting new shadow byte.
  always_comb begin
    cmd_sel = cmd_t'(({$bits(cmd_t){gnt[0]}} & cmd0) | ({$bits(cmd_t){gnt[1]}} & cmd1));
    port_ok = (cmd_sel.port < PIDX_W'(PORT_NUM));
    op_ok   = (cmd_sel.op <= RD_PIN);
    cur     = '0;
    if (port_ok) begin
      cur = cmd_sel.sel_port ? prt_q[cmd_sel.port] : ddr_q[cmd_sel.port];
    end
    case (cmd_sel.op)
      SET_BIT: new_d = cur |  bit_mask(cmd_sel.bit_idx);
      CLR_BIT: new_d = cur & ~bit_mask(cmd_sel.bit_idx);
      TGL_BIT: new_d = cur ^  bit_mask(cmd_sel.bit_idx);
      default: new_d = cmd_sel.wdata;
    endcase
  end

  // Command FSM, shadows and registered port/requester outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_q      <= 1'b0;
      sel_q     <= 1'b0;
      port_q    <= '0;
      cerr_q    <= 1'b0;
      new_q     <= '0;
      dane_q    <= '0;
      nr_ddr_q  <= '0;
      nr_port_q <= '0;
      nr_pin_q  <= '0;
      wr_ddr_q  <= 1'b0;
      wr_port_q <= 1'b0;
      ack_q     <= 2'b00;
      rerr_q    <= 1'b0;
      rdata_q   <= '0;
      for (int p = 0; p < PORT_NUM; p++) begin
        ddr_q[p] <= DDR_RST[p];
        prt_q[p] <= PORT_RST;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (req != 2'b00) begin
            rd_q   <= (cmd_sel.op == RD_PIN);
            sel_q  <= cmd_sel.sel_port;
            port_q <= cmd_sel.port;
            cerr_q <= !(port_ok && op_ok);
            new_q  <= new_d;
            // Port-side outputs are set up here so they are valid for
            // exactly the EXEC cycle.
            if (port_ok && op_ok) begin
              if (cmd_sel.op == RD_PIN) begin
                nr_pin_q <= cmd_sel.port;
              end else begin
                dane_q    <= new_d;
                nr_ddr_q  <= cmd_sel.port;
                nr_port_q <= cmd_sel.port;
                wr_ddr_q  <= !cmd_sel.sel_port;
                wr_port_q <= cmd_sel.sel_port;
              end
            end
            state_q <= EXEC;
          end
        end
        EXEC: begin
          wr_ddr_q  <= 1'b0;
          wr_port_q <= 1'b0;
          rerr_q    <= cerr_q;
          rdata_q   <= '0;
          if (!cerr_q) begin
            if (rd_q) begin
              rdata_q <= p_pin_in_i;
            end else begin
              rdata_q <= new_q;
              if (sel_q) begin
                prt_q[port_q] <= new_q;
              end else begin
                ddr_q[port_q] <= new_q;
              end
            end
          end
          ack_q   <= owner ? 2'b10 : 2'b01;
          state_q <= DONE;
        end
        DONE: begin
          ack_q   <= 2'b00;
          rerr_q  <= 1'b0;
          rdata_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req0_ack_o   = ack_q[0];
  assign req1_ack_o   = ack_q[1];
  assign req0_err_o   = ack_q[0] & rerr_q;
  assign req1_err_o   = ack_q[1] & rerr_q;
  assign req0_rdata_o = rdata_q;
  assign req1_rdata_o = rdata_q;
  assign p_dane_o     = dane_q;
  assign p_nr_ddr_o   = nr_ddr_q;
  assign p_nr_port_o  = nr_port_q;
  assign p_nr_pin_o   = nr_pin_q;
  assign p_wr_ddr_o   = wr_ddr_q;
  assign p_wr_port_o  = wr_port_q;
  assign busy_o       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_port_ctrl
// Description : Self-checking bench for port_ctrl. Directed scenarios plus
//               randomized two-requester traffic checked against a shadow
//               register model and round-robin ordering rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_port_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       r_valid [2];
  logic [2:0] r_op    [2];
  logic       r_reg   [2];
  logic [1:0] r_port  [2];
  logic [2:0] r_bit   [2];
  logic [7:0] r_wdata [2];

  logic       ack0, err0, ack1, err1, wr_ddr, wr_port, busy;
  logic [7:0] rdata0, rdata1, p_dane, pin_in;
  logic [1:0] nr_ddr, nr_port, nr_pin;

  logic [7:0] pins [3];
  assign pin_in = (nr_pin < 2'd3) ? pins[nr_pin] : 8'h00;

  port_ctrl dut (
    .clk(clk), .rst(rst),
    .req0_valid_i(r_valid[0]), .req0_op_i(r_op[0]), .req0_reg_i(r_reg[0]),
    .req0_port_i(r_port[0]), .req0_bit_i(r_bit[0]), .req0_wdata_i(r_wdata[0]),
    .req0_ack_o(ack0), .req0_err_o(err0), .req0_rdata_o(rdata0),
    .req1_valid_i(r_valid[1]), .req1_op_i(r_op[1]), .req1_reg_i(r_reg[1]),
    .req1_port_i(r_port[1]), .req1_bit_i(r_bit[1]), .req1_wdata_i(r_wdata[1]),
    .req1_ack_o(ack1), .req1_err_o(err1), .req1_rdata_o(rdata1),
    .p_dane_o(p_dane), .p_nr_ddr_o(nr_ddr), .p_nr_port_o(nr_port), .p_nr_pin_o(nr_pin),
    .p_wr_ddr_o(wr_ddr), .p_wr_port_o(wr_port), .p_pin_in_i(pin_in), .busy_o(busy)
  );

  int checks = 0;
  int errors = 0;
  int timeouts = 0;

  // ---------------- observation monitor (no judgements here) ----------------
  int n_wr_ddr = 0, n_wr_port = 0, n_ack0 = 0, n_ack1 = 0, n_overlap = 0;
  int strobe_run = 0, max_run = 0, n_acks = 0;
  logic [7:0] last_dane = 8'h00;
  logic [1:0] last_nr = 2'd0;
  int ack_who [1024];

  always @(negedge clk) begin
    if (wr_ddr) begin
      n_wr_ddr <= n_wr_ddr + 1; last_dane <= p_dane; last_nr <= nr_ddr;
    end
    if (wr_port) begin
      n_wr_port <= n_wr_port + 1; last_dane <= p_dane; last_nr <= nr_port;
    end
    if (wr_ddr || wr_port) begin
      strobe_run <= strobe_run + 1;
      if (strobe_run + 1 > max_run) max_run <= strobe_run + 1;
    end else begin
      strobe_run <= 0;
    end
    if (ack0 && ack1) n_overlap <= n_overlap + 1;
    if (ack0) n_ack0 <= n_ack0 + 1;
    if (ack1) n_ack1 <= n_ack1 + 1;
    if (ack0 || ack1) begin
      if (n_acks < 1024) ack_who[n_acks] <= ack1 ? 1 : 0;
      n_acks <= n_acks + 1;
    end
  end

  // ---------------- reference model: shadow registers ----------------
  logic [7:0] m_ddr [3];
  logic [7:0] m_prt [3];
  logic [8:0] q_act [$];
  logic [8:0] q_exp [$];

  task automatic model_reset();
    m_ddr[0] = 8'h00; m_ddr[1] = 8'h00; m_ddr[2] = 8'hFF;
    for (int i = 0; i < 3; i++) m_prt[i] = 8'h00;
  endtask

  // Result is {err, rdata}; rdata is meaningless when err is set.
  task automatic model_apply(input logic [2:0] op, input logic rg, input logic [1:0] port,
                             input logic [2:0] bt, input logic [7:0] wd, output logic [8:0] res);
    logic [7:0] cur, nv;
    if (port > 2'd2 || op > 3'd4) begin res = {1'b1, 8'h00}; return; end
    if (op == 3'd4) begin res = {1'b0, pins[port]}; return; end
    cur = rg ? m_prt[port] : m_ddr[port];
    case (op)
      3'd0:    nv = wd;
      3'd1:    nv = cur | (8'd1 << bt);
      3'd2:    nv = cur & ~(8'd1 << bt);
      default: nv = cur ^ (8'd1 << bt);
    endcase
    if (rg) m_prt[port] = nv; else m_ddr[port] = nv;
    res = {1'b0, nv};
  endtask

  // ---------------- stimulus drivers ----------------
  task automatic do_reset();
    rst = 1'b1;
    r_valid[0] = 1'b0; r_valid[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic issue1(input int who, input logic [2:0] op, input logic rg, input logic [1:0] port,
                        input logic [2:0] bt, input logic [7:0] wd, output int lat, output logic [8:0] act);
    bit got = 1'b0;
    @(posedge clk); #1;
    r_op[who] = op; r_reg[who] = rg; r_port[who] = port; r_bit[who] = bt; r_wdata[who] = wd;
    r_valid[who] = 1'b1;
    lat = 0; act = '0;
    while (!got && lat < 100) begin
      @(negedge clk); lat++;
      if (who == 0 && ack0) begin got = 1'b1; act = {err0, rdata0}; end
      if (who == 1 && ack1) begin got = 1'b1; act = {err1, rdata1}; end
    end
    @(posedge clk); #1 r_valid[who] = 1'b0;
    if (!got) lat = -1;
  endtask

  // Streams n commands; the next one is presented in the cycle after ack.
  task automatic issue_seq(input int who, input int n, input int mode);
    logic [2:0] op; logic rg; logic [1:0] port; logic [2:0] bt; logic [7:0] wd;
    logic [8:0] exp, act;
    int cyc, r; bit got;
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      r = $urandom_range(0, 9);
      if (mode == 0)  op = 3'd0;
      else if (r < 5) op = 3'(r);
      else if (r < 9) op = 3'($urandom_range(0, 3));
      else            op = 3'($urandom_range(5, 7));
      rg   = 1'($urandom_range(0, 1));
      port = (mode == 1 && $urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      bt   = 3'($urandom_range(0, 7));
      wd   = 8'($urandom);
      r_op[who] = op; r_reg[who] = rg; r_port[who] = port; r_bit[who] = bt; r_wdata[who] = wd;
      r_valid[who] = 1'b1;
      got = 1'b0; cyc = 0; act = '0;
      while (!got && cyc < 200) begin
        @(negedge clk); cyc++;
        if (who == 0 && ack0) begin got = 1'b1; act = {err0, rdata0}; end
        if (who == 1 && ack1) begin got = 1'b1; act = {err1, rdata1}; end
      end
      if (!got) begin timeouts++; break; end
      model_apply(op, rg, port, bt, wd, exp);
      q_act.push_back(act); q_exp.push_back(exp);
      @(posedge clk); #1;
      if (mode == 1 && $urandom_range(0, 2) == 0) begin
        r_valid[who] = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end
    r_valid[who] = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [36:0] outs;
    rst = 1'b1;
    r_valid[0] = 1'b1; r_valid[1] = 1'b1;
    r_op[0] = 3'd1; r_op[1] = 3'd0; r_reg[0] = 1'b1; r_reg[1] = 1'b0;
    r_port[0] = 2'd1; r_port[1] = 2'd2; r_bit[0] = 3'd5; r_bit[1] = 3'd0;
    r_wdata[0] = 8'h5A; r_wdata[1] = 8'hC3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    outs = {ack0, err0, rdata0, ack1, err1, rdata1, p_dane, nr_ddr, nr_port, nr_pin, wr_ddr, wr_port, busy};
    checks++;
    if (outs !== 37'd0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", outs);
    end
    r_valid[0] = 1'b0; r_valid[1] = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    outs = {ack0, err0, rdata0, ack1, err1, rdata1, p_dane, nr_ddr, nr_port, nr_pin, wr_ddr, wr_port, busy};
    checks++;
    if (outs !== 37'd0) begin
      errors++; $display("FAIL idle_after_reset got %h want 0", outs);
    end
    model_reset();
  endtask

  task automatic test_first_set();
    int lat, s_port, s_ddr, s_a1;
    logic [8:0] act, exp;
    do_reset();
    s_port = n_wr_port; s_ddr = n_wr_ddr; s_a1 = n_ack1;
    issue1(0, 3'd1, 1'b1, 2'd2, 3'd3, 8'h00, lat, act);
    model_apply(3'd1, 1'b1, 2'd2, 3'd3, 8'h00, exp);
    checks++; if (lat !== 3) begin errors++; $display("FAIL set_latency got %0d want 3", lat); end
    checks++; if (act !== {1'b0, 8'h08}) begin errors++; $display("FAIL set_rdata got %h want 008", act); end
    checks++; if (act !== exp) begin errors++; $display("FAIL set_model got %h want %h", act, exp); end
    checks++; if (n_wr_port - s_port !== 1) begin errors++; $display("FAIL set_wr_port_pulses got %0d want 1", n_wr_port - s_port); end
    checks++; if (n_wr_ddr - s_ddr !== 0) begin errors++; $display("FAIL set_wr_ddr_pulses got %0d want 0", n_wr_ddr - s_ddr); end
    checks++; if (last_dane !== 8'h08) begin errors++; $display("FAIL set_dane got %h want 08", last_dane); end
    checks++; if (last_nr !== 2'd2) begin errors++; $display("FAIL set_nr_port got %0d want 2", last_nr); end
    checks++; if (n_ack1 - s_a1 !== 0) begin errors++; $display("FAIL set_other_ack got %0d want 0", n_ack1 - s_a1); end
  endtask

  task automatic test_tgl();
    int lat;
    logic [8:0] act, exp;
    do_reset();
    pins[0] = 8'hF0;
    issue1(0, 3'd0, 1'b0, 2'd0, 3'd0, 8'h0F, lat, act);
    model_apply(3'd0, 1'b0, 2'd0, 3'd0, 8'h0F, exp);
    checks++; if (act !== exp) begin errors++; $display("FAIL wr_ddr_a got %h want %h", act, exp); end
    checks++; if (last_dane !== 8'h0F) begin errors++; $display("FAIL wr_ddr_a_dane got %h want 0f", last_dane); end
    issue1(1, 3'd0, 1'b1, 2'd0, 3'd0, 8'hA5, lat, act);
    model_apply(3'd0, 1'b1, 2'd0, 3'd0, 8'hA5, exp);
    checks++; if (act !== exp) begin errors++; $display("FAIL wr_port_a got %h want %h", act, exp); end
    issue1(0, 3'd3, 1'b1, 2'd0, 3'd0, 8'h00, lat, act);
    model_apply(3'd3, 1'b1, 2'd0, 3'd0, 8'h00, exp);
    checks++; if (act !== {1'b0, 8'hA4}) begin errors++; $display("FAIL tgl_rdata got %h want 0a4", act); end
    checks++; if (act !== exp) begin errors++; $display("FAIL tgl_model got %h want %h", act, exp); end
    checks++; if (last_dane !== 8'hA4) begin errors++; $display("FAIL tgl_dane got %h want a4", last_dane); end
  endtask

  task automatic test_rd_pin();
    int lat, s_port, s_ddr;
    logic [8:0] act;
    pins[0] = 8'h11; pins[1] = 8'h3C; pins[2] = 8'hC3;
    s_port = n_wr_port; s_ddr = n_wr_ddr;
    issue1(1, 3'd4, 1'b1, 2'd1, 3'd0, 8'h00, lat, act);
    checks++; if (act !== {1'b0, 8'h3C}) begin errors++; $display("FAIL rd_pin_rdata got %h want 03c", act); end
    checks++; if (nr_pin !== 2'd1) begin errors++; $display("FAIL rd_pin_index got %0d want 1", nr_pin); end
    checks++;
    if ((n_wr_port - s_port) + (n_wr_ddr - s_ddr) !== 0) begin
      errors++; $display("FAIL rd_pin_strobes got %0d want 0", (n_wr_port - s_port) + (n_wr_ddr - s_ddr));
    end
  endtask

  task automatic test_err();
    int lat, s_port, s_ddr;
    logic [8:0] act, exp;
    s_port = n_wr_port; s_ddr = n_wr_ddr;
    issue1(0, 3'd0, 1'b1, 2'd3, 3'd0, 8'hAA, lat, act);
    checks++; if (act[8] !== 1'b1) begin errors++; $display("FAIL err_bad_port got err=%b want 1", act[8]); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL err_latency got %0d want 3", lat); end
    issue1(1, 3'd6, 1'b0, 2'd0, 3'd0, 8'h55, lat, act);
    checks++; if (act[8] !== 1'b1) begin errors++; $display("FAIL err_bad_op got err=%b want 1", act[8]); end
    checks++;
    if ((n_wr_port - s_port) + (n_wr_ddr - s_ddr) !== 0) begin
      errors++; $display("FAIL err_strobes got %0d want 0", (n_wr_port - s_port) + (n_wr_ddr - s_ddr));
    end
    // Shadows must be untouched: a read-modify-write exposes their contents.
    issue1(0, 3'd2, 1'b1, 2'd0, 3'd2, 8'h00, lat, act);
    model_apply(3'd2, 1'b1, 2'd0, 3'd2, 8'h00, exp);
    checks++; if (act !== exp) begin errors++; $display("FAIL err_shadow_port_a got %h want %h", act, exp); end
    issue1(0, 3'd1, 1'b0, 2'd0, 3'd7, 8'h00, lat, act);
    model_apply(3'd1, 1'b0, 2'd0, 3'd7, 8'h00, exp);
    checks++; if (act !== exp) begin errors++; $display("FAIL err_shadow_ddr_a got %h want %h", act, exp); end
  endtask

  task automatic test_contention();
    int s, s_ov;
    do_reset();
    q_act.delete(); q_exp.delete();
    s = n_acks; s_ov = n_overlap; timeouts = 0;
    fork
      issue_seq(0, 4, 0);
      issue_seq(1, 4, 0);
    join
    @(negedge clk);
    checks++; if (timeouts !== 0) begin errors++; $display("FAIL cont_timeout got %0d want 0", timeouts); end
    checks++; if (n_acks - s !== 8) begin errors++; $display("FAIL cont_ack_count got %0d want 8", n_acks - s); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ack_who[s + i] !== (i % 2)) begin
        errors++; $display("FAIL cont_order[%0d] got req%0d want req%0d", i, ack_who[s + i], i % 2);
      end
    end
    checks++; if (n_overlap - s_ov !== 0) begin errors++; $display("FAIL cont_overlap got %0d want 0", n_overlap - s_ov); end
    for (int i = 0; i < q_exp.size(); i++) begin
      checks++;
      if (q_act[i] !== q_exp[i]) begin
        errors++; $display("FAIL cont_rdata[%0d] got %h want %h", i, q_act[i], q_exp[i]);
      end
    end
  endtask

  task automatic test_random();
    int s_ov;
    for (int i = 0; i < 3; i++) pins[i] = 8'($urandom);
    q_act.delete(); q_exp.delete();
    s_ov = n_overlap; timeouts = 0;
    fork
      issue_seq(0, 25, 1);
      issue_seq(1, 25, 1);
    join
    @(negedge clk);
    checks++; if (timeouts !== 0) begin errors++; $display("FAIL rand_timeout got %0d want 0", timeouts); end
    checks++; if (q_exp.size() !== 50) begin errors++; $display("FAIL rand_count got %0d want 50", q_exp.size()); end
    for (int i = 0; i < q_exp.size(); i++) begin
      checks++;
      if (q_exp[i][8] ? (q_act[i][8] !== 1'b1) : (q_act[i] !== q_exp[i])) begin
        errors++; $display("FAIL rand[%0d] got err/rdata %h want %h", i, q_act[i], q_exp[i]);
      end
    end
    checks++; if (n_overlap - s_ov !== 0) begin errors++; $display("FAIL rand_overlap got %0d want 0", n_overlap - s_ov); end
    checks++; if (max_run !== 1) begin errors++; $display("FAIL strobe_width got %0d cycles want 1", max_run); end
  endtask

  task automatic test_reset_mid();
    int s_a0, lat;
    logic [36:0] outs;
    logic [8:0] act, exp;
    do_reset();
    s_a0 = n_ack0;
    @(posedge clk); #1;
    r_op[0] = 3'd0; r_reg[0] = 1'b1; r_port[0] = 2'd1; r_bit[0] = 3'd0; r_wdata[0] = 8'h55;
    r_valid[0] = 1'b1;
    @(negedge clk);              // IDLE: grant
    @(posedge clk); #1;          // now in EXEC
    rst = 1'b1; r_valid[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    outs = {ack0, err0, rdata0, ack1, err1, rdata1, p_dane, nr_ddr, nr_port, nr_pin, wr_ddr, wr_port, busy};
    checks++; if (outs !== 37'd0) begin errors++; $display("FAIL midrst_outputs got %h want 0", outs); end
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (n_ack0 - s_a0 !== 0) begin errors++; $display("FAIL midrst_ack got %0d want 0", n_ack0 - s_a0); end
    model_reset();
    issue1(0, 3'd1, 1'b1, 2'd1, 3'd0, 8'h00, lat, act);
    model_apply(3'd1, 1'b1, 2'd1, 3'd0, 8'h00, exp);
    checks++; if (act !== exp) begin errors++; $display("FAIL midrst_port_b got %h want %h", act, exp); end
    issue1(1, 3'd3, 1'b0, 2'd2, 3'd0, 8'h00, lat, act);
    model_apply(3'd3, 1'b0, 2'd2, 3'd0, 8'h00, exp);
    checks++; if (act !== {1'b0, 8'hFE}) begin errors++; $display("FAIL midrst_ddr_c got %h want 0fe", act); end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      r_valid[i] = 1'b0; r_op[i] = 3'd0; r_reg[i] = 1'b0;
      r_port[i] = 2'd0; r_bit[i] = 3'd0; r_wdata[i] = 8'h00;
    end
    for (int i = 0; i < 3; i++) pins[i] = 8'h00;
    model_reset();
    test_reset();
    test_first_set();
    test_tgl();
    test_rd_pin();
    test_err();
    test_contention();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
